rnd_vec_check: RTL and testbench
================================

// Module: rnd_vec_check
// PURPOSE
//  Read-back checker for the memory tester. Regenerates the lagged additive pseudo-random
//  sequence that the write side put into memory, compares each returned read word against
//  it, and reports errors. Sits between the SDRAM read path and the status/OSD logic.
//  Seeding, mark (save) and rewind (restore) mirror the write-side generator, so identical
//  strobe patterns give identical sequences.
// PARAMETERS
//  OUT_SIZE      16  data word width (generator word width)
//  LFSR_LENGTH   55  generator lag length (words of state)
//  LFSR_FEEDBACK 24  generator feedback tap (1-based)
//  ADDR_W        24  width of read address tagged to each beat
//  ERR_W         16  error counter width (saturating)
// PORTS
//  clk            in   1         system clock, all logic on rising edge
//  rst_n          in   1         asynchronous active-low reset
//  init           in   1         seed strobe; its length in cycles selects the seed
//  mark           in   1         1-cycle strobe: save current generator state
//  rewind         in   1         1-cycle strobe: restore saved generator state
//  clr_err        in   1         1-cycle strobe: clear error status
//  rd_valid       in   1         read beat valid
//  rd_data        in   OUT_SIZE  read data word
//  rd_addr        in   ADDR_W    address of the beat
//  expected       out  OUT_SIZE  current expected word (state word 0), combinational
//  err_pulse      out  1         1-cycle pulse: previous-cycle beat mismatched
//  err_cnt        out  ERR_W     mismatching beats, saturates at all-ones
//  err_flag       out  1         sticky: at least one mismatch since reset/clr_err
//  first_err_addr out  ADDR_W    rd_addr of first mismatch
//  first_err_data out  OUT_SIZE  rd_data of first mismatch
//  first_err_exp  out  OUT_SIZE  expected of first mismatch
// BEHAVIOUR
//  - Reset: all state/saved words 0, all outputs 0 (expected=0).
//  - State: main[0..L-1], store[0..L-1], OUT_SIZE bits each. expected = main[0].
//  - Advance: main[i]<=main[i-1] for i>=1; sum=main[L-1]+main[FB-1] (mod 2^OUT_SIZE);
//    main[0]<={sum[msb:1], (|lsb of all main words) ? sum[0] : 1'b1} (anti-lockup).
//  - Priority per cycle: init > rewind > (advance on rd_valid, mark).
//  - init rising (init & !init_d): main[0][0]<=1, other bits kept; init held: advance each cycle.
//    rd_valid/mark/rewind during init are ignored (no compare, no advance).
//  - rewind: main<=store; a coincident rd_valid beat is dropped (not compared, no advance).
//  - rd_valid (no init/rewind): compare rd_data vs expected this cycle, register result,
//    advance. mark in same cycle saves the pre-advance state (same-edge semantics).
//  - Compare latency 1: mismatch on beat at cycle N -> err_pulse, err_cnt+1, err_flag at N+1.
//    first_err_* captured only when err_flag is 0 at the time of that update.
//  - clr_err: err_cnt<=0, err_flag<=0, first_err_*<=0; a mismatch registered in the same
//    update wins: err_cnt=1, err_flag=1, first_err_* = that beat.
//  - err_cnt saturates at 2^ERR_W-1; err_pulse still fires on each mismatch.
//  - Async reset mid-operation: everything returns to reset values immediately; sequence
//    restarts only after a new init.
// TESTING
//  1. Reset, init 1 cycle, 25 beats 0x0001, 0x0000 x23, 0x0001 -> err_cnt=0, err_flag=0.
//  2. As 1 but beat 5 = 0x0004 at rd_addr 0x000105 -> err_pulse next cycle, err_cnt=1,
//     first_err_addr=0x000105, first_err_data=0x0004, first_err_exp=0x0000.
//  3. mark on beat 10, run 30 beats, rewind, replay beats 10..39 -> no new errors.
//  4. ERR_W=4, 20 mismatching beats -> err_cnt=15, err_flag=1; clr_err -> all zero.
//  5. rd_valid during init and with rewind -> not compared, expected sequence unshifted.
//  6. rst_n low mid-run with err_cnt=3 -> all outputs 0 at once; re-init, test 1 passes.

Source files
------------

// File: rtl/rnd_vec_check.sv
// Read-back checker: regenerates the lagged additive sequence written to memory,
// compares each returned beat against it and keeps error statistics.
`timescale 1ns/1ps
module rnd_vec_check #(
    parameter int OUT_SIZE      = 16,
    parameter int LFSR_LENGTH   = 55,
    parameter int LFSR_FEEDBACK = 24,
    parameter int ADDR_W        = 24,
    parameter int ERR_W         = 16
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                init_i,
    input  logic                mark_i,
    input  logic                rewind_i,
    input  logic                clr_err_i,
    input  logic                rd_valid_i,
    input  logic [OUT_SIZE-1:0] rd_data_i,
    input  logic [ADDR_W-1:0]   rd_addr_i,
    output logic [OUT_SIZE-1:0] expected_o,
    output logic                err_pulse_o,
    output logic [ERR_W-1:0]    err_cnt_o,
    output logic                err_flag_o,
    output logic [ADDR_W-1:0]   first_err_addr_o,
    output logic [OUT_SIZE-1:0] first_err_data_o,
    output logic [OUT_SIZE-1:0] first_err_exp_o
);

    logic [OUT_SIZE-1:0]    main_q  [LFSR_LENGTH];
    logic [OUT_SIZE-1:0]    main_d  [LFSR_LENGTH];
    logic [OUT_SIZE-1:0]    store_q [LFSR_LENGTH];
    logic [OUT_SIZE-1:0]    store_d [LFSR_LENGTH];
    logic                   init_q;

    logic [LFSR_LENGTH-1:0] lsb_vec;
    logic                   any_lsb;
    logic [OUT_SIZE-1:0]    sum;
    logic [OUT_SIZE-1:0]    adv_word;
    logic                   advance;
    logic                   beat;
    logic                   mismatch;

    logic                   err_pulse_q, err_pulse_d;
    logic [ERR_W-1:0]       err_cnt_q, err_cnt_d;
    logic                   err_flag_q, err_flag_d;
    logic [ADDR_W-1:0]      first_addr_q, first_addr_d;
    logic [OUT_SIZE-1:0]    first_data_q, first_data_d;
    logic [OUT_SIZE-1:0]    first_exp_q, first_exp_d;

    genvar gi;
    generate
        for (gi = 0; gi < LFSR_LENGTH; gi++) begin : g_lsb
            assign lsb_vec[gi] = main_q[gi][0];
        end
    endgenerate

    // An all-even state would never produce an odd word again, so force the LSB high.
    assign any_lsb  = |lsb_vec;
    assign sum      = main_q[LFSR_LENGTH-1] + main_q[LFSR_FEEDBACK-1];
    assign adv_word = {sum[OUT_SIZE-1:1], any_lsb ? sum[0] : 1'b1};

    always_comb begin
        main_d  = main_q;
        store_d = store_q;
        advance = 1'b0;
        beat    = 1'b0;
        if (init_i) begin
            if (!init_q) begin
                main_d[0][0] = 1'b1;
            end else begin
                advance = 1'b1;
            end
        end else if (rewind_i) begin
            main_d = store_q;
        end else begin
            if (mark_i) begin
                store_d = main_q;
            end
            if (rd_valid_i) begin
                beat    = 1'b1;
                advance = 1'b1;
            end
        end
        if (advance) begin
            main_d[0] = adv_word;
            for (int i = 1; i < LFSR_LENGTH; i++) begin
                main_d[i] = main_q[i-1];
            end
        end
    end

    assign mismatch = beat && (rd_data_i != main_q[0]);

    always_comb begin
        err_pulse_d  = mismatch;
        err_cnt_d    = err_cnt_q;
        err_flag_d   = err_flag_q;
        first_addr_d = first_addr_q;
        first_data_d = first_data_q;
        first_exp_d  = first_exp_q;
        if (clr_err_i) begin
            err_cnt_d    = '0;
            err_flag_d   = 1'b0;
            first_addr_d = '0;
            first_data_d = '0;
            first_exp_d  = '0;
        end
        // Evaluated after the clear so a coincident mismatch becomes the new first error.
        if (mismatch) begin
            if (!err_flag_d) begin
                first_addr_d = rd_addr_i;
                first_data_d = rd_data_i;
                first_exp_d  = main_q[0];
            end
            if (err_cnt_d != '1) begin
                err_cnt_d = err_cnt_d + ERR_W'(1);
            end
            err_flag_d = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < LFSR_LENGTH; i++) begin
                main_q[i]  <= '0;
                store_q[i] <= '0;
            end
            init_q       <= 1'b0;
            err_pulse_q  <= 1'b0;
            err_cnt_q    <= '0;
            err_flag_q   <= 1'b0;
            first_addr_q <= '0;
            first_data_q <= '0;
            first_exp_q  <= '0;
        end else begin
            main_q       <= main_d;
            store_q      <= store_d;
            init_q       <= init_i;
            err_pulse_q  <= err_pulse_d;
            err_cnt_q    <= err_cnt_d;
            err_flag_q   <= err_flag_d;
            first_addr_q <= first_addr_d;
            first_data_q <= first_data_d;
            first_exp_q  <= first_exp_d;
        end
    end

    assign expected_o       = main_q[0];
    assign err_pulse_o      = err_pulse_q;
    assign err_cnt_o        = err_cnt_q;
    assign err_flag_o       = err_flag_q;
    assign first_err_addr_o = first_addr_q;
    assign first_err_data_o = first_data_q;
    assign first_err_exp_o  = first_exp_q;

endmodule

// File: tb/tb_rnd_vec_check.sv
// Scoreboarded bench for rnd_vec_check: a window-of-words sequence model predicts every
// cycle's outputs; a negedge monitor compares them against two DUTs (ERR_W 16 and 4).
`timescale 1ns/1ps
module tb_rnd_vec_check;

    localparam int L  = 55;
    localparam int FB = 24;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        init, mark, rewind, clr_err, rd_valid;
    logic [15:0] rd_data;
    logic [23:0] rd_addr;

    logic [15:0] expected, fdata, fexp;
    logic        err_pulse, err_flag;
    logic [15:0] err_cnt;
    logic [23:0] faddr;

    logic [15:0] expected4, fdata4, fexp4;
    logic        err_pulse4, err_flag4;
    logic [3:0]  err_cnt4;
    logic [23:0] faddr4;

    always #5 clk = ~clk;

    rnd_vec_check u_dut (
        .clk(clk), .rst_n(rst_n), .init_i(init), .mark_i(mark), .rewind_i(rewind),
        .clr_err_i(clr_err), .rd_valid_i(rd_valid), .rd_data_i(rd_data), .rd_addr_i(rd_addr),
        .expected_o(expected), .err_pulse_o(err_pulse), .err_cnt_o(err_cnt),
        .err_flag_o(err_flag), .first_err_addr_o(faddr), .first_err_data_o(fdata),
        .first_err_exp_o(fexp)
    );

    rnd_vec_check #(.ERR_W(4)) u_dut4 (
        .clk(clk), .rst_n(rst_n), .init_i(init), .mark_i(mark), .rewind_i(rewind),
        .clr_err_i(clr_err), .rd_valid_i(rd_valid), .rd_data_i(rd_data), .rd_addr_i(rd_addr),
        .expected_o(expected4), .err_pulse_o(err_pulse4), .err_cnt_o(err_cnt4),
        .err_flag_o(err_flag4), .first_err_addr_o(faddr4), .first_err_data_o(fdata4),
        .first_err_exp_o(fexp4)
    );

    typedef struct packed {
        logic [15:0] exp;
        logic        pulse;
        logic [15:0] cnt;
        logic [3:0]  cnt4;
        logic        flag;
        logic [23:0] fa;
        logic [15:0] fd;
        logic [15:0] fe;
    } rec_t;

    rec_t sb[$];

    int n_chk  = 0;
    int n_fail = 0;

    // Model: win[0] is the newest generated word, win[L-1] the oldest still in use.
    logic [15:0] win[$];
    logic [15:0] saved[$];
    logic        m_init_prev, m_pulse, m_flag;
    logic [15:0] m_cnt, m_fd, m_fe;
    logic [3:0]  m_cnt4;
    logic [23:0] m_fa;

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] want);
        n_chk++;
        if (got !== want) begin
            n_fail++;
            $display("FAIL %s: got %h, want %h (t=%0t)", nm, got, want, $time);
        end
    endtask

    function automatic void model_reset();
        win.delete();
        saved.delete();
        for (int i = 0; i < L; i++) begin
            win.push_back(16'h0);
            saved.push_back(16'h0);
        end
        m_init_prev = 1'b0;
        m_pulse = 1'b0; m_flag = 1'b0; m_cnt = '0; m_cnt4 = '0;
        m_fa = '0; m_fd = '0; m_fe = '0;
    endfunction

    function automatic void model_next();
        logic        odd_seen;
        logic [15:0] s;
        odd_seen = 1'b0;
        for (int i = 0; i < L; i++) odd_seen |= win[i][0];
        s = win[L-1] + win[FB-1];
        if (!odd_seen) s[0] = 1'b1;
        win.push_front(s);
        void'(win.pop_back());
    endfunction

    function automatic rec_t model_outputs();
        rec_t r;
        r.exp = win[0]; r.pulse = m_pulse; r.cnt = m_cnt; r.cnt4 = m_cnt4;
        r.flag = m_flag; r.fa = m_fa; r.fd = m_fd; r.fe = m_fe;
        return r;
    endfunction

    function automatic void model_update(input logic i_init, input logic i_mark,
                                         input logic i_rew, input logic i_clr,
                                         input logic i_val, input logic [15:0] d,
                                         input logic [23:0] a);
        logic        bad;
        logic [15:0] want, tmp;
        bad  = 1'b0;
        want = win[0];
        if (i_init) begin
            if (!m_init_prev) begin
                tmp = win[0]; tmp[0] = 1'b1; win[0] = tmp;
            end else begin
                model_next();
            end
        end else if (i_rew) begin
            win = saved;
        end else begin
            if (i_mark) saved = win;
            if (i_val) begin
                bad = (d != want);
                model_next();
            end
        end
        m_pulse = bad;
        if (i_clr) begin
            m_cnt = '0; m_cnt4 = '0; m_flag = 1'b0; m_fa = '0; m_fd = '0; m_fe = '0;
        end
        if (bad) begin
            if (!m_flag) begin
                m_fa = a; m_fd = d; m_fe = want;
            end
            if (m_cnt != 16'hFFFF) m_cnt = m_cnt + 16'd1;
            if (m_cnt4 != 4'hF) m_cnt4 = m_cnt4 + 4'd1;
            m_flag = 1'b1;
        end
        m_init_prev = i_init;
    endfunction

    // Called at posedge+1: drive this cycle's inputs, queue what the DUT shows now.
    task automatic step(input logic i_init, input logic i_mark, input logic i_rew,
                        input logic i_clr, input logic i_val, input logic [15:0] d,
                        input logic [23:0] a);
        init = i_init; mark = i_mark; rewind = i_rew; clr_err = i_clr;
        rd_valid = i_val; rd_data = d; rd_addr = a;
        if (i_val) $display("beat addr=%h data=%h init=%b rew=%b mark=%b clr=%b",
                            a, d, i_init, i_rew, i_mark, i_clr);
        sb.push_back(model_outputs());
        model_update(i_init, i_mark, i_rew, i_clr, i_val, d, a);
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 16'($urandom), 24'h0);
    endtask

    task automatic good_beat(input logic [23:0] a, input logic i_mark);
        step(1'b0, i_mark, 1'b0, 1'b0, 1'b1, win[0], a);
    endtask

    task automatic bad_beat(input logic [23:0] a, input logic i_clr);
        step(1'b0, 1'b0, 1'b0, i_clr, 1'b1, win[0] ^ 16'h8001, a);
    endtask

    task automatic rst_cycles(input int n);
        rst_n = 1'b0;
        init = 1'b0; mark = 1'b0; rewind = 1'b0; clr_err = 1'b0; rd_valid = 1'b0;
        rd_data = '0; rd_addr = '0;
        model_reset();
        #1;
        chk("rst_expected", expected, 32'h0);
        chk("rst_err_cnt", err_cnt, 32'h0);
        chk("rst_err_flag", err_flag, 32'h0);
        chk("rst_first_addr", faddr, 32'h0);
        for (int i = 0; i < n; i++) begin
            sb.push_back(model_outputs());
            @(posedge clk);
            #1;
        end
        rst_n = 1'b1;
    endtask

    task automatic test_seq1();
        step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0, 24'h0);
        for (int i = 0; i < 25; i++)
            step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, (i == 0 || i == 24) ? 16'h0001 : 16'h0000,
                 24'(i));
        idle();
        chk("t1_err_cnt", err_cnt, 32'h0);
        chk("t1_err_flag", err_flag, 32'h0);
    endtask

    always @(negedge clk) begin
        rec_t r;
        if (sb.size() > 0) begin
            r = sb.pop_front();
            chk("expected", expected, r.exp);
            chk("err_pulse", err_pulse, r.pulse);
            chk("err_cnt", err_cnt, r.cnt);
            chk("err_cnt4", err_cnt4, r.cnt4);
            chk("err_flag", err_flag, r.flag);
            chk("err_flag4", err_flag4, r.flag);
            chk("first_err_addr", faddr, r.fa);
            chk("first_err_data", fdata, r.fd);
            chk("first_err_exp", fexp, r.fe);
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, want finish by 200000 ns");
        $fatal(1, "timeout");
    end

    initial begin
        logic [15:0] rec_data[30];
        int          r;

        rst_cycles(3);
        @(posedge clk);
        #1;

        // 1: known start of sequence after a one-cycle init
        test_seq1();

        // 2: single corrupted beat at address 0x000105
        rst_cycles(2);
        step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0, 24'h0);
        for (int i = 0; i < 25; i++)
            step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1,
                 (i == 5) ? 16'h0004 : ((i == 0 || i == 24) ? 16'h0001 : 16'h0000),
                 24'h000100 + 24'(i));
        chk("t2_err_cnt", err_cnt, 32'h1);
        chk("t2_err_flag", err_flag, 32'h1);
        chk("t2_first_addr", faddr, 32'h000105);
        chk("t2_first_data", fdata, 32'h0004);
        chk("t2_first_exp", fexp, 32'h0000);

        // 3 + 5: init held with beats (ignored), mark/rewind replay, rewind drops a beat
        rst_cycles(2);
        for (int i = 0; i < 4; i++)
            step(1'b1, 1'(i & 1), 1'b0, 1'b0, 1'b1, 16'($urandom), 24'hAA0000);
        for (int i = 0; i < 10; i++) good_beat(24'h200000 + 24'(i), 1'b0);
        for (int i = 10; i < 40; i++) begin
            rec_data[i-10] = win[0];
            good_beat(24'h200000 + 24'(i), i == 10);
        end
        step(1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 16'($urandom), 24'hBB0000);
        for (int i = 10; i < 40; i++)
            step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, rec_data[i-10], 24'h200000 + 24'(i));
        idle();
        chk("t3_err_cnt", err_cnt, 32'h0);
        chk("t3_err_flag", err_flag, 32'h0);

        // 4: saturation of the 4-bit counter, then clear, then clear with a coincident error
        for (int i = 0; i < 20; i++) bad_beat(24'h300000 + 24'(i), 1'b0);
        idle();
        chk("t4_err_cnt4_sat", err_cnt4, 32'hF);
        chk("t4_err_cnt16", err_cnt, 32'd20);
        chk("t4_first_addr", faddr, 32'h300000);
        step(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 16'h0, 24'h0);
        chk("t4_clr_cnt4", err_cnt4, 32'h0);
        chk("t4_clr_flag", err_flag4, 32'h0);
        chk("t4_clr_addr", faddr, 32'h0);
        good_beat(24'h310000, 1'b0);
        bad_beat(24'h310001, 1'b0);
        bad_beat(24'h310002, 1'b1);
        chk("t4_clr_win_cnt", err_cnt, 32'h1);
        chk("t4_clr_win_addr", faddr, 32'h310002);

        // randomized mix of strobes and beats
        for (int i = 0; i < 400; i++) begin
            r = int'($urandom_range(0, 99));
            if (r < 3)
                step(1'b1, 1'($urandom), 1'($urandom), 1'b0, 1'($urandom), 16'($urandom),
                     24'($urandom));
            else if (r < 6)
                step(1'b0, 1'b0, 1'b1, 1'b0, 1'($urandom), 16'($urandom), 24'($urandom));
            else
                step(1'b0, (r < 11), 1'b0, (r >= 95), (r < 80),
                     ($urandom_range(0, 9) == 0) ? 16'($urandom) : win[0], 24'($urandom));
        end

        // 6: asynchronous reset with three errors outstanding, then a clean restart
        step(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 16'h0, 24'h0);
        for (int i = 0; i < 3; i++) bad_beat(24'h400000 + 24'(i), 1'b0);
        idle();
        chk("t6_err_cnt_pre", err_cnt, 32'h3);
        #2;
        rst_cycles(2);
        test_seq1();

        for (int i = 0; i < 10 && sb.size() > 0; i++) @(negedge clk);
        #1;
        chk("scoreboard_drained", 32'(sb.size()), 32'h0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
